// File: rtl/fifo_rd_stream_pkg.sv
// Shared helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  // Bit width of the beat counter; never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO of {data, last} entries; clear has priority over push/pop.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{data: push_data, last: push_last};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[rd_ptr_q].data;
  assign head_last = mem_q[rd_ptr_q].last;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && occ_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clear && occ_q == 2'd0));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read FIFO into a valid/ready stream with a 2-entry
// prefetch buffer, per-burst m_last tagging and synchronous flush.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int            CW      = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

  logic          inflight_q, inflight_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    occ;
  logic          pop;
  logic          arrive;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  // The word landing during a flush belongs to the discarded stream.
  assign arrive  = inflight_q && !flush;

  always_comb begin
    // Space check counts this cycle's pop, so the buffer streams at full rate.
    fifo_rinc  = rst_n && !fifo_rempty && !flush &&
                 (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    inflight_d = fifo_rinc;
    cnt_d      = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (arrive) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // Last is decided at load time since loads and beats share one order.
  stream_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (arrive),
    .push_data (fifo_rdata),
    .push_last (cnt_q == CNT_MAX),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data),
    .head_last (m_last)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench: FIFO environment model plus a word-queue
// scoreboard that tracks which popped words must still be delivered.
module tb_fifo_rd_stream;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_rempty = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_rinc, m_valid, m_last;
  logic [31:0] m_data;
  logic        fifo_rinc1, m_valid1, m_last1;
  logic [31:0] m_data1;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q[$];
  logic [31:0] pending[$];
  int          idx = 0;
  int          beats = 0;
  int          last1_cnt = 0;
  bit          take = 0;
  bit          exp_invalid = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  fifo_rd_stream #(.WIDTH(32), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  fifo_rd_stream #(.WIDTH(32), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc1), .flush(flush), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_last(m_last1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w);
    q.push_back(w);
    fifo_rempty = 1'b0;
  endtask

  // One clock: observe at the falling edge, then act as the FIFO after the rising edge.
  task automatic tick();
    logic [31:0] w;
    logic        exp_last;
    @(negedge clk);
    take = 0;
    if (rst_n) begin
      total++;
      if (fifo_rinc && fifo_rempty) begin
        bad++; $display("FAIL rinc_empty: fifo_rinc=1 required 0 while empty");
      end
      total++;
      if (fifo_rinc1 !== fifo_rinc) begin
        bad++; $display("FAIL rinc_bl1: got %b required %b", fifo_rinc1, fifo_rinc);
      end
      if (exp_invalid) begin
        total++;
        if (m_valid !== 1'b0) begin
          bad++; $display("FAIL flush_valid: m_valid=%b required 0", m_valid);
        end
      end
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          bad++;
          $display("FAIL hold: v=%b d=%h l=%b required v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (pending.size() == 0) begin
          bad++; $display("FAIL spurious_beat: got d=%h required no beat", m_data);
        end else begin
          exp_last = (idx == BL - 1);
          if (m_data !== pending[0] || m_last !== exp_last) begin
            bad++;
            $display("FAIL beat: d=%h l=%b required d=%h l=%b",
                     m_data, m_last, pending[0], exp_last);
          end
          total++;
          if (m_valid1 !== 1'b1 || m_data1 !== pending[0] || m_last1 !== 1'b1) begin
            bad++;
            $display("FAIL beat_bl1: v=%b d=%h l=%b required v=1 d=%h l=1",
                     m_valid1, m_data1, m_last1, pending[0]);
          end
          if (m_last1 === 1'b1) last1_cnt++;
          $display("beat %0d data=%h last=%b", beats, m_data, m_last);
          void'(pending.pop_front());
          idx   = (idx + 1) % BL;
          beats++;
        end
      end
      exp_invalid = flush;
      prev_stall  = m_valid && !m_ready && !flush;
      prev_data   = m_data;
      prev_last   = m_last;
      if (flush) begin
        pending.delete();
        idx = 0;
      end
      take = fifo_rinc;
      total++;
      if (pending.size() + int'(take) > 2) begin
        bad++; $display("FAIL outstanding: got %0d required <=2", pending.size() + int'(take));
      end
    end
    @(posedge clk);
    #1;
    if (take && rst_n && q.size() > 0) begin
      w = q.pop_front();
      fifo_rdata = w;
      pending.push_back(w);
    end
    fifo_rempty = (q.size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h11 + i);
    #12;
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 || fifo_rinc !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: v=%b l=%b d=%h rinc=%b required all 0",
               m_valid, m_last, m_data, fifo_rinc);
    end
    total++;
    if (m_valid1 !== 1'b0 || m_data1 !== 32'h0 || fifo_rinc1 !== 1'b0) begin
      bad++; $display("FAIL reset_state_bl1: v=%b d=%h rinc=%b required 0", m_valid1, m_data1, fifo_rinc1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int n;
    m_ready = 1'b1;
    #1;
    total++;
    if (fifo_rinc !== 1'b1) begin
      bad++; $display("FAIL first_rinc: got %b required 1", fifo_rinc);
    end
    n = 0;
    while (beats < 8 && n < 30) begin tick(); n++; end
    total++;
    if (n != 10) begin
      bad++; $display("FAIL stream_cycles: 8 beats took %0d cycles required 10", n);
    end
  endtask

  task automatic test_backpressure();
    int c;
    for (int i = 0; i < 8; i++) push_word(32'h11 + i);
    c = 0;
    while (beats < 16 && c < 40) begin
      m_ready = !(c >= 3 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        total++;
        if (fifo_rinc !== 1'b0 || m_valid !== 1'b1) begin
          bad++; $display("FAIL stall_full: rinc=%b v=%b required rinc=0 v=1", fifo_rinc, m_valid);
        end
      end
      tick();
      c++;
    end
    total++;
    if (beats != 16 || q.size() != 0 || pending.size() != 0) begin
      bad++; $display("FAIL bp_drain: beats=%0d q=%0d pend=%0d required 16 0 0", beats, q.size(), pending.size());
    end
  endtask

  task automatic test_single();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fifo_rinc !== 1'b0) begin
        bad++; $display("FAIL idle_rinc: got %b required 0", fifo_rinc);
      end
    end
    push_word(32'hA5);
    #1;
    total++;
    if (fifo_rinc !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL single_issue: rinc=%b v=%b required 1 0", fifo_rinc, m_valid);
    end
    tick();
    #1;
    total++;
    if (fifo_rinc !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL single_pulse: rinc=%b v=%b required 0 0", fifo_rinc, m_valid);
    end
    tick();
    #1;
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'hA5 || m_last !== 1'b0) begin
      bad++; $display("FAIL single_arrive: v=%b d=%h l=%b required 1 a5 0", m_valid, m_data, m_last);
    end
    m_ready = 1'b1;
    tick();
    tick();
    total++;
    if (m_valid !== 1'b0 || pending.size() != 0) begin
      bad++; $display("FAIL single_drain: v=%b pend=%0d required 0 0", m_valid, pending.size());
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    total++;
    if (fifo_rinc !== 1'b0) begin
      bad++; $display("FAIL flush_rinc: got %b required 0", fifo_rinc);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL flush_next: m_valid=%b required 0", m_valid);
    end
  endtask

  task automatic drain(input string name);
    int n;
    m_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || pending.size() != 0) && n < 60) begin tick(); n++; end
    total++;
    if (q.size() != 0 || pending.size() != 0) begin
      bad++; $display("FAIL %s: q=%0d pend=%0d required 0 0", name, q.size(), pending.size());
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_word(32'h31 + i);
    for (int i = 0; i < 5; i++) tick();
    do_flush();
    drain("flush_stream_drain");
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h41 + i);
    for (int i = 0; i < 5; i++) tick();
    do_flush();
    drain("flush_full_drain");
  endtask

  task automatic test_burst1();
    int b0, l0;
    b0 = beats;
    l0 = last1_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h51 + i);
    drain("bl1_drain");
    total++;
    if (beats - b0 != 3 || last1_cnt - l0 != 3) begin
      bad++; $display("FAIL bl1_last: beats=%0d lasts=%0d required 3 3", beats - b0, last1_cnt - l0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) push_word($urandom);
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    drain("random_drain");
  endtask

  task automatic test_async_reset();
    int b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(32'h61 + i);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (m_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_valid: got %b required 1", m_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 || fifo_rinc !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: v=%b l=%b d=%h rinc=%b required all 0",
               m_valid, m_last, m_data, fifo_rinc);
    end
    q.delete();
    pending.delete();
    idx = 0;
    fifo_rempty = 1'b1;
    fifo_rdata = '0;
    prev_stall = 0;
    exp_invalid = 0;
    tick();
    rst_n = 1'b1;
    b0 = beats;
    for (int i = 0; i < 8; i++) push_word(32'h71 + i);
    drain("post_reset_drain");
    total++;
    if (beats - b0 != 8) begin
      bad++; $display("FAIL post_reset_beats: got %0d required 8", beats - b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_single();
    test_flush();
    test_burst1();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
